// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with HI/LO result registers
//
// Executes mult/multu/div/divu one bit per cycle (WIDTH+1 cycles per op) and
// holds results in the architectural HI/LO registers, which mthi/mtlo may also
// write while the unit is idle. Signed ops run on magnitudes; signs are
// applied in the final FIX cycle.
//
// Optional feature macro: MDU_FAST_MULT_EN
//   defined   - mult/multu use a single-cycle combinational product
//               (result after one edge); div/divu stay iterative.
//   undefined - every op uses the iterative path.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start, op       start request; op 00 mult, 01 multu, 10 div, 11 divu
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   flush           squash the in-flight op (no HI/LO update, no done)
//   wr_hi, wr_lo    mthi/mtlo strobes with wr_data, honoured only when idle
//   busy            op in flight (state != IDLE)
//   done            one-cycle pulse after an op has updated HI/LO
//   hi, lo          HI/LO registers

module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic [WIDTH-1:0]     b_q;      // |src_b|: multiplicand or divisor
    logic [2*WIDTH-1:0]   acc_q;    // mul: {partial, multiplier}; div: {rem, dividend/quotient}
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 signed_op;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    // Operand magnitudes; abs(min) wraps to min, which is the correct unsigned magnitude.
    assign signed_op = ~op[0];
    assign neg_a     = signed_op & src_a[WIDTH-1];
    assign neg_b     = signed_op & src_b[WIDTH-1];
    assign abs_a     = neg_a ? (WIDTH'(0) - src_a) : src_a;
    assign abs_b     = neg_b ? (WIDTH'(0) - src_b) : src_b;

    always_comb begin
        // Shift-add multiply step: add multiplicand to upper half if LSB set, shift right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide step. The extra top bit keeps the borrow exact even
        // when the shifted remainder overflows WIDTH bits (divide by zero).
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, b_q};
        if (div_diff[WIDTH+1]) begin
            div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        acc_d = op_q[1] ? div_step : mul_step;

        prod = acc_q;
`ifdef MDU_FAST_MULT_EN
        if (!op_q[1]) begin
            prod = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end
`endif
        // Sign flags are only latched for signed ops, so unsigned ops never negate.
        mul_res = (sign_a_q ^ sign_b_q) ? (-prod) : prod;

        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];

        if (op_q[1]) begin
            // Divide by zero leaves rem = |a|; re-applying sign(a) restores src_a.
            lo_d = (b_q == '0) ? {WIDTH{1'b1}}
                 : ((sign_a_q ^ sign_b_q) ? (WIDTH'(0) - quo) : quo);
            hi_d = sign_a_q ? (WIDTH'(0) - rem) : rem;
        end else begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_hi) hi_q <= wr_data;
                    if (wr_lo) lo_q <= wr_data;
                    if (start && !flush) begin
                        op_q     <= op;
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        b_q      <= abs_b;
                        acc_q    <= {{WIDTH{1'b0}}, abs_a};
                        cnt_q    <= CW'(WIDTH - 1);
                        state_q  <= S_RUN;
`ifdef MDU_FAST_MULT_EN
                        if (!op[1]) state_q <= S_FIX;
`endif
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter

module tb_mdu_iter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int passed = 0;
    int total  = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int exp_latency(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
        return o[1] ? W + 1 : 1;
`else
        return W + 1;
`endif
    endfunction

    // Called just after a rising edge; returns just after the done edge (in the done cycle).
    // poke > 0 pulses an extra divu start that cycle, which must be ignored while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int poke);
        int  n;
        bit  seen;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 100) begin
            if (n == poke && poke > 0) begin
                start = 1'b1;
                op    = 2'b11;
                src_a = 32'd1;
                src_b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(exp_latency(o)));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int dcount;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        src_a   = '0;
        src_b   = '0;
        flush   = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Ignored start mid-operation must not disturb the multu result.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // Back-to-back: each start issued in the previous op's done cycle.
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("div_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

        // mthi in idle.
        @(posedge clk);
        #1;
        wr_hi   = 1'b1;
        wr_data = 32'h1234;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);

        // Flush mid-RUN together with an ignored start and mthi.
        op    = 2'b10;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_pre_busy", 64'(busy), 64'd1);
        start   = 1'b1;
        wr_hi   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        check("flush_lo", 64'(lo), 64'hFFFF_FFFF);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("flush_no_done", 64'(dcount), 64'd0);
        check("flush_hi_late", 64'(hi), 64'h1234);

        // Reset mid-RUN, then a fresh op completes normally.
        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(done), 64'd0);
        check("rst_run_hi", 64'(hi), 64'd0);
        check("rst_run_lo", 64'(lo), 64'd0);
        run_op("after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
